// File: rtl/lut_layer_pkg.sv
// Shared constants and FSM state encoding
// for the programmable LUT neuron layer.
package lut_layer_pkg;

  localparam int DEF_NEURONS  = 4;
  localparam int DEF_FANIN    = 4;
  localparam int DEF_IN_BITS  = 2;
  localparam int DEF_OUT_BITS = 2;

  localparam int DEF_ADDR_W  = DEF_FANIN * DEF_IN_BITS;
  localparam int DEF_DEPTH   = 1 << DEF_ADDR_W;
  localparam int DEF_ENTRIES = DEF_NEURONS * DEF_DEPTH;
  localparam int DEF_CNT_W   = $clog2(DEF_ENTRIES);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron truth table: sync write port,
// async read port, distributed storage.
module lut_neuron_ram #(
  parameter int ADDR_W   = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [OUT_BITS-1:0] wdata_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [OUT_BITS-1:0] rdata_o
);

  (* rom_style="distributed" *)
  logic [OUT_BITS-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lut_neuron_layer_prog.sv
// Runtime-loadable layer of LUT neurons with a
// serial table loader and a 1-cycle output stage.
module lut_neuron_layer_prog
  import lut_layer_pkg::*;
#(
  parameter int NEURONS  = DEF_NEURONS,
  parameter int FANIN    = DEF_FANIN,
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic                          cfg_valid,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          cfg_done,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NEURONS*FANIN*IN_BITS-1:0] s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NEURONS*OUT_BITS-1:0]   m_data
);

  localparam int AW      = FANIN * IN_BITS;
  localparam int DEPTH   = 1 << AW;
  localparam int ENTRIES = NEURONS * DEPTH;
  localparam int CW      = $clog2(ENTRIES);
  localparam logic [CW-1:0] LAST = CW'(ENTRIES - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic mv_q, mv_d;
  logic [NEURONS*OUT_BITS-1:0] md_q, md_d;
  logic [NEURONS*OUT_BITS-1:0] lut_rd;
  logic [CW-1:0] sel;
  logic fire;
  logic wr_en;

  assign s_ready  = (state_q == RUN) && (!mv_q || m_ready);
  assign fire     = s_valid && s_ready;
  assign wr_en    = (state_q == LOAD) && cfg_valid && !cfg_start;
  assign sel      = cnt_q >> AW;
  assign cfg_done = done_q;
  assign m_valid  = mv_q;
  assign m_data   = md_q;

  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    logic we;
    assign we = wr_en && (sel == CW'(n));
    lut_neuron_ram #(
      .ADDR_W  (AW),
      .OUT_BITS(OUT_BITS)
    ) u_ram (
      .clk    (clk),
      .we_i   (we),
      .waddr_i(cnt_q[AW-1:0]),
      .wdata_i(cfg_data),
      .raddr_i(s_data[n*AW +: AW]),
      .rdata_o(lut_rd[n*OUT_BITS +: OUT_BITS])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      UNCFG: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  // A (re)load flushes any held result immediately.
  always_comb begin
    mv_d = mv_q;
    md_d = md_q;
    if (cfg_start) begin
      mv_d = 1'b0;
    end else if (fire) begin
      mv_d = 1'b1;
      md_d = lut_rd;
    end else if (m_ready) begin
      mv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCFG;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      mv_q    <= 1'b0;
      md_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
    end
  end

endmodule

// File: tb/tb_lut_neuron_layer_prog.sv
// Bench for lut_neuron_layer_prog: table-level
// model checked every cycle plus literal checks.
module tb_lut_neuron_layer_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_data = '0;
  logic        cfg_done;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;

  int tests = 0;
  int fails = 0;

  // model: 0=unconfigured, 1=loading, 2=running
  logic [1:0] tbl [4][256];
  int         mst = 0;
  int         mcnt = 0;
  bit         mmv = 0;
  bit         mdone = 0;
  logic [7:0] mmd = '0;

  lut_neuron_layer_prog dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_done (cfg_done),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lookup(logic [31:0] d);
    logic [7:0] r;
    for (int n = 0; n < 4; n++) r[n*2 +: 2] = tbl[n][d[n*8 +: 8]];
    return r;
  endfunction

  function automatic logic [1:0] pat(int mode, int i);
    int n;
    int a;
    n = i / 256;
    a = i % 256;
    case (mode)
      0:       return 2'((a ^ n) & 3);
      1:       return 2'b01;
      2:       return 2'b10;
      default: return 2'(((a >> 2) ^ n) & 3);
    endcase
  endfunction

  always @(negedge clk) begin
    bit exp_sr;
    exp_sr = (mst == 2) && (!mmv || m_ready);
    chk("s_ready", s_ready, exp_sr);
    chk("m_valid", m_valid, mmv);
    chk("cfg_done", cfg_done, mdone);
    if (mmv) chk("m_data", m_data, mmd);
    if (rst) begin
      mst = 0; mcnt = 0; mmv = 0; mmd = '0; mdone = 0;
    end else begin
      mdone = 0;
      if (cfg_start) begin
        mst = 1; mcnt = 0; mmv = 0;
      end else if (mst == 1) begin
        if (cfg_valid) begin
          tbl[mcnt / 256][mcnt % 256] = cfg_data;
          if (mcnt == 1023) begin
            mst = 2; mdone = 1;
          end
          mcnt++;
        end
      end else if (mst == 2) begin
        if (s_valid && exp_sr) begin
          mmv = 1; mmd = lookup(s_data);
        end else if (m_ready) begin
          mmv = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic entries(int mode, int cnt);
    for (int i = 0; i < cnt; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = pat(mode, i);
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic load_body(int mode);
    entries(mode, 1023);
    cfg_valid = 1'b1;
    cfg_data  = pat(mode, 1023);
    chk("done_early", cfg_done, 0);
    step();
    cfg_valid = 1'b0;
    chk("done_pulse", cfg_done, 1);
    step();
    chk("done_single", cfg_done, 0);
  endtask

  task automatic load(int mode);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    load_body(mode);
  endtask

  task automatic xfer(string nm, logic [31:0] d, logic [7:0] e);
    s_valid = 1'b1;
    s_data  = d;
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    chk({nm, "_v"}, m_valid, 1);
    chk(nm, m_data, e);
  endtask

  initial begin
    for (int n = 0; n < 4; n++)
      for (int a = 0; a < 256; a++) tbl[n][a] = '0;

    step();
    step();
    rst = 1'b0;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_cfg_done", cfg_done, 0);

    // 1: xor pattern
    load(0);
    xfer("t1_a", 32'h03020100, 8'h00);
    xfer("t1_b", 32'h00000003, 8'hE7);
    xfer("t1_c", 32'hFF00FF00, 8'h28);
    step();

    // 2: stall then random stream
    s_valid = 1'b1;
    s_data  = 32'h01020304;
    m_ready = 1'b0;
    step();
    s_data = 32'hA5A5A5A5;
    for (int k = 0; k < 5; k++) begin
      chk("t2_stall_rdy", s_ready, 0);
      chk("t2_stall_data", m_data, 8'h88);
      step();
    end
    for (int k = 0; k < 16; k++) begin
      bit acc;
      int guard;
      s_data = $urandom;
      guard  = 0;
      do begin
        m_ready = 1'($urandom_range(0, 1));
        #1;
        acc = s_ready;
        step();
        guard++;
      end while (!acc && guard < 40);
      if (!acc) chk("t2_timeout", 0, 1);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    step();

    // 3: flush on reload, then all-01 tables
    s_valid = 1'b1;
    s_data  = 32'h11223344;
    m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    chk("t3_held", m_valid, 1);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("t3_flush_v", m_valid, 0);
    chk("t3_flush_rdy", s_ready, 0);
    load_body(1);
    xfer("t3_55", 32'hDEADBEEF, 8'h55);

    // 4: restart mid-load discards that entry
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    entries(2, 500);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 2'b11;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    load_body(2);
    xfer("t4_a", 32'h00000000, 8'hAA);
    xfer("t4_b", 32'hFFFFFFFF, 8'hAA);
    xfer("t4_c", 32'h12345678, 8'hAA);
    xfer("t4_d", 32'h00F401F4, 8'hAA);

    // 5: reset mid-load
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    entries(0, 300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rdy", s_ready, 0);
    chk("t5_mv", m_valid, 0);
    cfg_valid = 1'b1;
    cfg_data  = 2'b11;
    repeat (5) step();
    cfg_valid = 1'b0;
    s_valid   = 1'b1;
    #1;
    chk("t5_uncfg_rdy", s_ready, 0);
    step();
    s_valid = 1'b0;
    chk("t5_no_out", m_valid, 0);
    load(3);

    // 6: cfg writes ignored in RUN
    cfg_valid = 1'b1;
    cfg_data  = 2'b11;
    repeat (4) step();
    cfg_valid = 1'b0;
    xfer("t6_zero", 32'h00000000, 8'hE4);
    xfer("t6_ones", 32'hFFFFFFFF, 8'h1B);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] d;
      d = $urandom;
      xfer("t6_rand", d, lookup(d));
    end
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
